// File: rtl/radd_mp_seq.sv
// rtl/radd_mp_seq.sv - multi-precision sequential add controller around an 8-bit adder
module radd_mp_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a_in,
    input  logic [8*NBYTES-1:0] b_in,
    input  logic                cin_in,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                cout_out,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_cin,
    input  logic [7:0]          add_sum,
    input  logic                add_cout
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    acc;
    logic [W-1:0]    acc_next;
    logic            carry;
    logic [IDXW-1:0] idx;
    logic            accept;

    // A new operation may only be taken when no byte walk is in flight.
    assign accept = start && (state != S_RUN);

    // The accumulator collects sum bytes from the top down so that the
    // least-significant byte ends up at bit 0 after NBYTES shifts.
    generate
        if (NBYTES == 1) begin : g_acc_single
            assign acc_next = add_sum;
        end else begin : g_acc_multi
            assign acc_next = {add_sum, acc[W-1:8]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and outputs; adder operands come only from registers.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        add_a      = 8'd0;
        add_b      = 8'd0;
        add_cin    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                busy    = 1'b1;
                add_a   = a_sh[7:0];
                add_b   = b_sh[7:0];
                add_cin = carry;
                if (idx == LAST_IDX) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = start ? S_RUN : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand shifters, carry chain and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            result   <= '0;
            cout_out <= 1'b0;
        end else if (accept) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin_in;
            idx   <= '0;
        end else if (state == S_RUN) begin
            acc   <= acc_next;
            carry <= add_cout;
            a_sh  <= a_sh >> 8;
            b_sh  <= b_sh >> 8;
            idx   <= idx + 1'b1;
            if (idx == LAST_IDX) begin
                result   <= acc_next;
                cout_out <= add_cout;
            end
        end
    end

endmodule

// File: tb/tb_radd_mp_seq.sv
// tb/tb_radd_mp_seq.sv - randomized self-checking bench for radd_mp_seq
module tb_radd_mp_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a_in, b_in;
    logic        cin_in;
    logic        busy, done, cout_out, add_cin, add_cout;
    logic [31:0] result;
    logic [7:0]  add_a, add_b, add_sum;

    logic        start1;
    logic [7:0]  a1, b1;
    logic        cin1;
    logic        busy1, done1, cout1, add_cin1, add_cout1;
    logic [7:0]  result1, add_a1, add_b1, add_sum1;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] exp_res = '0;
    logic        exp_cout = 1'b0;

    always #5 clk = ~clk;

    // Behavioural 8-bit adders standing in for radd8.
    assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {8'd0, add_cin1};

    radd_mp_seq #(.NBYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .cin_in(cin_in), .busy(busy), .done(done), .result(result),
        .cout_out(cout_out), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    radd_mp_seq #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1),
        .cin_in(cin1), .busy(busy1), .done(done1), .result(result1),
        .cout_out(cout1), .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1)
    );

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        nvec++;
        if ({busy, done, cout_out, result, add_a, add_b, add_cin} !== 52'd0) begin
            nerr++;
            $display("FAIL reset4 got=%h exp=0", {busy, done, cout_out, result, add_a, add_b, add_cin});
        end
        nvec++;
        if ({busy1, done1, cout1, result1, add_a1, add_b1, add_cin1} !== 28'd0) begin
            nerr++;
            $display("FAIL reset1 got=%h exp=0", {busy1, done1, cout1, result1, add_a1, add_b1, add_cin1});
        end
        rst_n = 1'b1;
    endtask

    // One full operation; optionally pulses start with junk operands in RUN cycle 'inject'.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input int inject, input string tag);
        logic [32:0] full;
        logic [63:0] mask, part, tmp;
        logic [31:0] sa, sb;
        logic [18:0] exp_bus;
        full = {1'b0, a} + {1'b0, b} + {32'd0, c};
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; cin_in = c;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            mask = (64'd1 << (8 * (k - 1))) - 64'd1;
            part = ({32'd0, a} & mask) + ({32'd0, b} & mask) + {63'd0, c};
            tmp  = part >> (8 * (k - 1));
            sa   = a >> (8 * (k - 1));
            sb   = b >> (8 * (k - 1));
            exp_bus = {1'b1, 1'b0, sa[7:0], sb[7:0], tmp[0]};
            nvec++;
            if ({busy, done, add_a, add_b, add_cin} !== exp_bus) begin
                nerr++;
                $display("FAIL %s run%0d bus got=%h exp=%h", tag, k, {busy, done, add_a, add_b, add_cin}, exp_bus);
            end
            nvec++;
            if ({cout_out, result} !== {exp_cout, exp_res}) begin
                nerr++;
                $display("FAIL %s run%0d held result got=%h exp=%h", tag, k, {cout_out, result}, {exp_cout, exp_res});
            end
            start = (k == inject);
            a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        nvec++;
        if ({busy, done, add_a, add_b, add_cin} !== 19'h20000) begin
            nerr++;
            $display("FAIL %s done bus got=%h exp=20000", tag, {busy, done, add_a, add_b, add_cin});
        end
        nvec++;
        if ({cout_out, result} !== full) begin
            nerr++;
            $display("FAIL %s sum got=%h exp=%h", tag, {cout_out, result}, full);
        end
        {exp_cout, exp_res} = full;
        @(negedge clk);
        nvec++;
        if ({busy, done, add_a, add_b, add_cin} !== 19'h0) begin
            nerr++;
            $display("FAIL %s idle bus got=%h exp=0", tag, {busy, done, add_a, add_b, add_cin});
        end
    endtask

    task automatic test_directed();
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, "carry_ripple");
        nvec++;
        if ({cout_out, result} !== {1'b1, 32'h00000000}) begin
            nerr++;
            $display("FAIL carry_ripple const got=%h exp=100000000", {cout_out, result});
        end
        run_op(32'h12345678, 32'h11111111, 1'b1, 0, "mixed");
        nvec++;
        if ({cout_out, result} !== {1'b0, 32'h2345678A}) begin
            nerr++;
            $display("FAIL mixed const got=%h exp=02345678a", {cout_out, result});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_op($urandom, $urandom, 1'($urandom), 0, "random");
    endtask

    task automatic test_ignore_start();
        run_op($urandom, $urandom, 1'($urandom), 2, "ignore_start");
        repeat (3) begin
            @(negedge clk);
            nvec++;
            if ({busy, done} !== 2'b00) begin
                nerr++;
                $display("FAIL ignore_start extra got=%b exp=00", {busy, done});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] q[$];
        logic [32:0] e;
        for (int n = 0; n <= 25; n++) begin
            if (n > 0) begin
                nvec++;
                if ({busy, done} !== {(n % 5) != 0, (n % 5) == 0}) begin
                    nerr++;
                    $display("FAIL b2b n%0d busy/done got=%b exp=%b", n, {busy, done}, {(n % 5) != 0, (n % 5) == 0});
                end
                if ((n % 5) == 0 && q.size() > 0) begin
                    e = q.pop_front();
                    nvec++;
                    if ({cout_out, result} !== e) begin
                        nerr++;
                        $display("FAIL b2b n%0d sum got=%h exp=%h", n, {cout_out, result}, e);
                    end
                    {exp_cout, exp_res} = e;
                end
            end
            a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom);
            start = (n < 25);
            if ((n % 5) == 0 && n < 25)
                q.push_back({1'b0, a_in} + {1'b0, b_in} + {32'd0, cin_in});
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1; a_in = 32'hDEADBEEF; b_in = 32'h01020304; cin_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({busy, done, cout_out, result, add_a, add_b, add_cin} !== 52'd0) begin
            nerr++;
            $display("FAIL abort clear got=%h exp=0", {busy, done, cout_out, result, add_a, add_b, add_cin});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_res = '0; exp_cout = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nvec++;
            if ({busy, done, cout_out, result} !== 35'd0) begin
                nerr++;
                $display("FAIL abort quiet%0d got=%h exp=0", i, {busy, done, cout_out, result});
            end
        end
        run_op($urandom, $urandom, 1'($urandom), 0, "after_abort");
    endtask

    task automatic test_nbytes1();
        logic [7:0] ta, tb;
        logic       tc;
        logic [8:0] full;
        for (int i = 0; i < 5; i++) begin
            ta = (i == 0) ? 8'h80 : 8'($urandom);
            tb = (i == 0) ? 8'h80 : 8'($urandom);
            tc = (i == 0) ? 1'b0 : 1'($urandom);
            full = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
            @(negedge clk);
            start1 = 1'b1; a1 = ta; b1 = tb; cin1 = tc;
            @(negedge clk);
            start1 = 1'b0;
            nvec++;
            if ({busy1, done1, add_a1, add_b1, add_cin1} !== {2'b10, ta, tb, tc}) begin
                nerr++;
                $display("FAIL nb1 run%0d got=%h exp=%h", i, {busy1, done1, add_a1, add_b1, add_cin1}, {2'b10, ta, tb, tc});
            end
            @(negedge clk);
            nvec++;
            if ({busy1, done1, cout1, result1} !== {2'b01, full}) begin
                nerr++;
                $display("FAIL nb1 done%0d got=%h exp=%h", i, {busy1, done1, cout1, result1}, {2'b01, full});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_nbytes1();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
